// File: rtl/rgb_grid_sampler_if.sv
// Sample stream between the grid sampler and the LED-matrix transmitters.
// The master side presents the FIFO head; the slave side returns smp_ready.
interface rgb_grid_sampler_if #(
  parameter int CB = 8,
  parameter int XW = 4,
  parameter int YW = 3
);
  logic            smp_valid;
  logic            smp_ready;
  logic [3*CB-1:0] smp_data;
  logic [XW-1:0]   smp_x;
  logic [YW-1:0]   smp_y;
  logic            smp_last;

  modport master (
    output smp_valid, smp_data, smp_x, smp_y, smp_last,
    input  smp_ready
  );

  modport slave (
    input  smp_valid, smp_data, smp_x, smp_y, smp_last,
    output smp_ready
  );
endinterface

// File: rtl/rgb_grid_sampler.sv
// Samples a GRID_W x GRID_H grid out of the decoded DVI pixel stream at a
// configurable origin and stride. Each sample is truncated to COLOR_BITS per
// channel and queued in a small FIFO that feeds a valid/ready stream.
module rgb_grid_sampler #(
  parameter int GRID_W     = 16,
  parameter int GRID_H     = 8,
  parameter int X0         = 0,
  parameter int Y0         = 0,
  parameter int STEP_X     = 1,
  parameter int STEP_Y     = 1,
  parameter int COLOR_BITS = 8,
  parameter int FIFO_DEPTH = 16,
  parameter bit VS_POL     = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rgb_vs,
  input  logic               rgb_de,
  input  logic [7:0]         rgb_r,
  input  logic [7:0]         rgb_g,
  input  logic [7:0]         rgb_b,
  rgb_grid_sampler_if.master smp,
  output logic               frame_start,
  output logic               overflow,
  output logic               incomplete
);

  localparam int CB  = COLOR_BITS;
  localparam int XW  = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int YW  = (GRID_H > 1) ? $clog2(GRID_H) : 1;
  localparam int GXW = XW + 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = 16;
  localparam int EW  = 3 * CB + XW + YW + 1;

  localparam logic [GXW-1:0] GX_END  = GXW'(GRID_W);
  localparam logic [GXW-1:0] GX_LAST = GXW'(GRID_W - 1);
  localparam logic [YW-1:0]  GY_LAST = YW'(GRID_H - 1);
  localparam logic [CW-1:0]  X0_C    = CW'(X0);
  localparam logic [CW-1:0]  Y0_C    = CW'(Y0);
  localparam logic [CW-1:0]  SX_C    = CW'(STEP_X);
  localparam logic [CW-1:0]  SY_C    = CW'(STEP_Y);

  // Sync edge detection
  logic vs_act;
  logic vs_act_d;
  logic de_d;
  logic vs_edge;
  logic de_fall;

  // Raster position and grid tracking
  logic [CW-1:0]  px;
  logic [CW-1:0]  ln;
  logic [CW-1:0]  next_px;
  logic [CW-1:0]  next_ln;
  logic [GXW-1:0] gx;
  logic [YW-1:0]  gy;
  logic           armed;
  logic           capture;
  logic           last_hit;
  logic           row_end;
  logic [EW-1:0]  cap_entry;

  // Capture stage and FIFO
  logic           s1_valid;
  logic [EW-1:0]  s1_entry;
  logic [EW-1:0]  mem [FIFO_DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic           full;
  logic           empty;
  logic           pop;
  logic           push;
  logic           drop;
  logic [EW-1:0]  head;

  assign vs_act  = (rgb_vs == VS_POL);
  assign vs_edge = vs_act && !vs_act_d;
  assign de_fall = de_d && !rgb_de;

  assign last_hit  = (gx == GX_LAST) && (gy == GY_LAST);
  assign capture   = armed && rgb_de && (px == next_px) && (ln == next_ln) &&
                     (gx < GX_END) && !vs_edge;
  assign row_end   = armed && de_fall && (ln == next_ln) && !vs_edge;
  assign cap_entry = {rgb_r[7 -: CB], rgb_g[7 -: CB], rgb_b[7 -: CB],
                      gx[XW-1:0], gy, last_hit};

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign pop   = !empty && smp.smp_ready;
  assign push  = s1_valid && (!full || pop);
  assign drop  = s1_valid && full && !pop;
  assign head  = mem[rd_ptr[AW-1:0]];

  assign smp.smp_valid = !empty;
  assign smp.smp_data  = empty ? '0 : head[EW-1 -: 3*CB];
  assign smp.smp_x     = empty ? '0 : head[YW+1 +: XW];
  assign smp.smp_y     = empty ? '0 : head[1 +: YW];
  assign smp.smp_last  = empty ? 1'b0 : head[0];

  // Previous-cycle sync flops; vs starts "active" so a real edge needs an inactive phase first
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_act_d <= 1'b1;
      de_d     <= 1'b0;
    end else begin
      vs_act_d <= vs_act;
      de_d     <= rgb_de;
    end
  end

  // Pixel index within the line and line index within the frame
  always_ff @(posedge clk) begin
    if (!rst_n || vs_edge) begin
      px <= '0;
      ln <= '0;
    end else begin
      px <= rgb_de ? px + 1'b1 : '0;
      if (de_fall) ln <= ln + 1'b1;
    end
  end

  // Next sample target: column advances per capture, row advances when the target line ends
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      armed   <= 1'b0;
      gx      <= '0;
      gy      <= '0;
      next_px <= X0_C;
      next_ln <= Y0_C;
    end else if (vs_edge) begin
      armed   <= 1'b1;
      gx      <= '0;
      gy      <= '0;
      next_px <= X0_C;
      next_ln <= Y0_C;
    end else if (capture) begin
      gx      <= gx + 1'b1;
      next_px <= next_px + SX_C;
      if (last_hit) armed <= 1'b0;
    end else if (row_end) begin
      gx      <= '0;
      next_px <= X0_C;
      next_ln <= next_ln + SY_C;
      if (gy == GY_LAST) armed <= 1'b0;
      else               gy    <= gy + 1'b1;
    end
  end

  // One-cycle capture register so a sample reaches the FIFO head two cycles after its pixel
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_entry <= '0;
    end else begin
      s1_valid <= capture;
      if (capture) s1_entry <= cap_entry;
    end
  end

  // FIFO storage; contents need no reset because the outputs are masked while empty
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= s1_entry;
  end

  // FIFO pointers with an extra wrap bit to tell full from empty
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Frame pulse and per-frame sticky status
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
      overflow    <= 1'b0;
      incomplete  <= 1'b0;
    end else begin
      frame_start <= vs_edge;
      if (vs_edge) begin
        overflow   <= 1'b0;
        incomplete <= armed;
      end else if (drop) begin
        overflow   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rgb_grid_sampler.sv
// Self-checking bench: two sampler instances (strided 4x3 grid with 4-bit colour
// and a 4-deep FIFO; default 16x8 grid with active-low vs) watch the same random video.
module tb_rgb_grid_sampler;

  localparam int A_W = 4, A_H = 3, A_X0 = 2, A_Y0 = 1, A_SX = 3, A_SY = 2, A_FD = 4;
  localparam int B_W = 16, B_H = 8;

  typedef struct packed {
    logic [23:0] data;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        last;
  } smp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic vs, de;
  logic [7:0] r, g, b;
  logic vs_b;
  logic fs_a, ovf_a, inc_a, fs_b, ovf_b, inc_b;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int fs_cnt_a, fs_cnt_b;
  int first_pix_cyc_b, first_valid_cyc_b;
  bit prev_done_a = 1'b1, prev_done_b = 1'b1;
  bit done_a, done_b;
  smp_t exp_a[$], exp_b[$], obs_a[$], obs_b[$];

  assign vs_b = ~vs;

  rgb_grid_sampler_if #(.CB(4), .XW(2), .YW(2)) if_a ();
  rgb_grid_sampler_if #(.CB(8), .XW(4), .YW(3)) if_b ();

  rgb_grid_sampler #(
    .GRID_W(A_W), .GRID_H(A_H), .X0(A_X0), .Y0(A_Y0), .STEP_X(A_SX), .STEP_Y(A_SY),
    .COLOR_BITS(4), .FIFO_DEPTH(A_FD), .VS_POL(1'b1)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .rgb_vs(vs), .rgb_de(de),
    .rgb_r(r), .rgb_g(g), .rgb_b(b), .smp(if_a),
    .frame_start(fs_a), .overflow(ovf_a), .incomplete(inc_a)
  );

  rgb_grid_sampler #(.VS_POL(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .rgb_vs(vs_b), .rgb_de(de),
    .rgb_r(r), .rgb_g(g), .rgb_b(b), .smp(if_b),
    .frame_start(fs_b), .overflow(ovf_b), .incomplete(inc_b)
  );

  always #5 clk = ~clk;

  // Cycle stamp used to measure capture latency
  always @(posedge clk) cyc <= cyc + 1;

  // Collect every accepted sample and count frame pulses, sampled mid-cycle
  always @(negedge clk) begin
    smp_t e;
    if (if_a.smp_valid && if_a.smp_ready) begin
      e.data = 24'(if_a.smp_data); e.x = 8'(if_a.smp_x);
      e.y = 8'(if_a.smp_y); e.last = if_a.smp_last;
      obs_a.push_back(e);
    end
    if (if_b.smp_valid && if_b.smp_ready) begin
      e.data = 24'(if_b.smp_data); e.x = 8'(if_b.smp_x);
      e.y = 8'(if_b.smp_y); e.last = if_b.smp_last;
      obs_b.push_back(e);
    end
    if (if_b.smp_valid && first_valid_cyc_b < 0) first_valid_cyc_b = cyc;
    if (fs_a) fs_cnt_a++;
    if (fs_b) fs_cnt_b++;
  end

  // Pixel colour as a function of raster position and a per-frame seed
  function automatic logic [23:0] pix(input int px, input int ln, input logic [31:0] seed);
    logic [7:0] pr, pg, pb;
    pr = 8'(px * 5 + int'(seed[7:0]));
    pg = 8'(ln * 3 + int'(seed[15:8]));
    pb = 8'(px * ln) ^ seed[23:16];
    return {pr, pg, pb};
  endfunction

  // Reference: enumerate grid points in order, keep those that fall inside the frame
  task automatic build_exp(input int width, input int lines, input logic [31:0] seed);
    smp_t e;
    logic [23:0] p;
    int l, c;
    exp_a.delete();
    exp_b.delete();
    for (int gy = 0; gy < A_H; gy++)
      for (int gx = 0; gx < A_W; gx++) begin
        l = A_Y0 + gy * A_SY;
        c = A_X0 + gx * A_SX;
        if (l < lines && c < width) begin
          p = pix(c, l, seed);
          e.data = {12'd0, p[23:20], p[15:12], p[7:4]};
          e.x = 8'(gx); e.y = 8'(gy);
          e.last = (gx == A_W - 1) && (gy == A_H - 1);
          exp_a.push_back(e);
        end
      end
    for (int gy = 0; gy < B_H; gy++)
      for (int gx = 0; gx < B_W; gx++)
        if (gy < lines && gx < width) begin
          e.data = pix(gx, gy, seed);
          e.x = 8'(gx); e.y = 8'(gy);
          e.last = (gx == B_W - 1) && (gy == B_H - 1);
          exp_b.push_back(e);
        end
    done_a = (A_Y0 + (A_H - 1) * A_SY) < lines;
    done_b = (B_H - 1) < lines;
  endtask

  // mode 0: both ready; 1: A stalled, B random; 2: both stalled
  task automatic set_ready(input int mode);
    case (mode)
      0:       begin if_a.smp_ready = 1'b1; if_b.smp_ready = 1'b1; end
      1:       begin if_a.smp_ready = 1'b0; if_b.smp_ready = 1'($urandom_range(0, 1)); end
      default: begin if_a.smp_ready = 1'b0; if_b.smp_ready = 1'b0; end
    endcase
  endtask

  // One video frame: vsync pulse, blanking, active lines, then drain and check
  task automatic run_frame(input int width, input int lines, input int mode, input int rst_line);
    logic [31:0] seed;
    int n, j;
    bit found;
    seed = $urandom;
    build_exp(width, lines, seed);
    obs_a.delete(); obs_b.delete();
    fs_cnt_a = 0; fs_cnt_b = 0;
    first_pix_cyc_b = -1; first_valid_cyc_b = -1;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1; vs = 1'b1; de = 1'b0; set_ready(mode);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1; vs = 1'b0; set_ready(mode);
    end
    @(negedge clk);
    checks++;
    if (inc_a !== !prev_done_a) begin
      errors++; $display("[TB] FAIL incomplete_a: got %b expected %b", inc_a, !prev_done_a);
    end
    checks++;
    if (inc_b !== !prev_done_b) begin
      errors++; $display("[TB] FAIL incomplete_b: got %b expected %b", inc_b, !prev_done_b);
    end
    checks++;
    if ({ovf_a, ovf_b} !== 2'b00) begin
      errors++; $display("[TB] FAIL overflow_cleared: got %b%b expected 00", ovf_a, ovf_b);
    end

    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < width; p++) begin
        @(posedge clk); #1;
        de = 1'b1;
        {r, g, b} = pix(p, l, seed);
        set_ready(mode);
        if (l == 0 && p == 0) first_pix_cyc_b = cyc;
        if (l == rst_line && p == width / 2) rst_n = 1'b0;
        if (l == rst_line && p == width / 2 + 1) begin
          rst_n = 1'b1;
          @(negedge clk);
          checks++;
          if ({if_a.smp_valid, if_a.smp_data, if_a.smp_x, if_a.smp_y, if_a.smp_last,
               fs_a, ovf_a, inc_a} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs_a: got v=%b d=%h ovf=%b inc=%b expected all 0",
                     if_a.smp_valid, if_a.smp_data, ovf_a, inc_a);
          end
          checks++;
          if ({if_b.smp_valid, if_b.smp_data, if_b.smp_x, if_b.smp_y, if_b.smp_last,
               fs_b, ovf_b, inc_b} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs_b: got v=%b d=%h ovf=%b inc=%b expected all 0",
                     if_b.smp_valid, if_b.smp_data, ovf_b, inc_b);
          end
        end
      end
      for (int i = 0; i < 3 + int'($urandom_range(0, 3)); i++) begin
        @(posedge clk); #1; de = 1'b0; set_ready(mode);
      end
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1; de = 1'b0; set_ready(0);
    end
    @(negedge clk);

    checks++;
    if (fs_cnt_a != 1 || fs_cnt_b != 1) begin
      errors++; $display("[TB] FAIL frame_start_count: got %0d/%0d expected 1/1", fs_cnt_a, fs_cnt_b);
    end

    if (rst_line >= 0) begin
      checks++;
      if (obs_a.size() != 0 || obs_b.size() != 0) begin
        errors++;
        $display("[TB] FAIL no_capture_after_reset: got %0d/%0d samples expected 0/0",
                 obs_a.size(), obs_b.size());
      end
      checks++;
      if ({ovf_a, inc_a, ovf_b, inc_b} !== 4'b0000) begin
        errors++; $display("[TB] FAIL flags_after_reset: got %b expected 0000", {ovf_a, inc_a, ovf_b, inc_b});
      end
      prev_done_a = 1'b1;
      prev_done_b = 1'b1;
      return;
    end

    // Instance A: all samples, or only the first FIFO_DEPTH when stalled
    n = (mode == 1 && exp_a.size() > A_FD) ? A_FD : exp_a.size();
    checks++;
    if (obs_a.size() != n) begin
      errors++; $display("[TB] FAIL count_a: got %0d expected %0d", obs_a.size(), n);
    end
    for (int i = 0; i < n && i < obs_a.size(); i++) begin
      checks++;
      if (obs_a[i] !== exp_a[i]) begin
        errors++; $display("[TB] FAIL sample_a[%0d]: got %h expected %h", i, obs_a[i], exp_a[i]);
      end
    end
    checks++;
    if (ovf_a !== (mode == 1 && exp_a.size() > A_FD)) begin
      errors++; $display("[TB] FAIL overflow_a: got %b expected %b", ovf_a, (mode == 1 && exp_a.size() > A_FD));
    end

    // Instance B: exact under full readiness, ordered subsequence under backpressure
    if (mode == 1) begin
      j = 0;
      for (int i = 0; i < obs_b.size(); i++) begin
        found = 1'b0;
        while (j < exp_b.size() && !found) begin
          if (obs_b[i] === exp_b[j]) found = 1'b1;
          j++;
        end
        checks++;
        if (!found) begin
          errors++; $display("[TB] FAIL order_b[%0d]: got %h expected a later grid sample", i, obs_b[i]);
        end
      end
      checks++;
      if (ovf_b !== (obs_b.size() < exp_b.size())) begin
        errors++;
        $display("[TB] FAIL overflow_b: got %b expected %b (%0d of %0d delivered)",
                 ovf_b, (obs_b.size() < exp_b.size()), obs_b.size(), exp_b.size());
      end
    end else begin
      checks++;
      if (obs_b.size() != exp_b.size()) begin
        errors++; $display("[TB] FAIL count_b: got %0d expected %0d", obs_b.size(), exp_b.size());
      end
      for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++) begin
        checks++;
        if (obs_b[i] !== exp_b[i]) begin
          errors++; $display("[TB] FAIL sample_b[%0d]: got %h expected %h", i, obs_b[i], exp_b[i]);
        end
      end
      checks++;
      if (ovf_b !== 1'b0) begin
        errors++; $display("[TB] FAIL overflow_b: got %b expected 0", ovf_b);
      end
      checks++;
      if (first_valid_cyc_b - first_pix_cyc_b != 2) begin
        errors++;
        $display("[TB] FAIL latency_b: got %0d expected 2", first_valid_cyc_b - first_pix_cyc_b);
      end
    end
    prev_done_a = done_a;
    prev_done_b = done_b;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vs = 1'b0; de = 1'b0; r = '0; g = '0; b = '0;
    set_ready(0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({if_a.smp_valid, if_a.smp_data, if_a.smp_x, if_a.smp_y, if_a.smp_last,
         fs_a, ovf_a, inc_a} !== '0) begin
      errors++; $display("[TB] FAIL reset_a: got v=%b d=%h expected all 0", if_a.smp_valid, if_a.smp_data);
    end
    checks++;
    if ({if_b.smp_valid, if_b.smp_data, if_b.smp_x, if_b.smp_y, if_b.smp_last,
         fs_b, ovf_b, inc_b} !== '0) begin
      errors++; $display("[TB] FAIL reset_b: got v=%b d=%h expected all 0", if_b.smp_valid, if_b.smp_data);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    // Active video before any vsync must be ignored
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1; de = 1'b1; r = 8'(i);
    end
    @(posedge clk); #1; de = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({if_a.smp_valid, if_b.smp_valid} !== 2'b00) begin
      errors++; $display("[TB] FAIL disarmed_before_vs: got %b%b expected 00", if_a.smp_valid, if_b.smp_valid);
    end
  endtask

  task automatic test_random_frames();
    for (int k = 0; k < 3; k++)
      run_frame(int'($urandom_range(16, 24)), int'($urandom_range(8, 12)), 0, -1);
  endtask

  task automatic test_short_lines();
    run_frame(10, 9, 0, -1);
  endtask

  task automatic test_backpressure();
    run_frame(20, 10, 1, -1);
  endtask

  task automatic test_incomplete();
    run_frame(20, 3, 0, -1);
    run_frame(20, 10, 0, -1);
    run_frame(18, 9, 0, -1);
  endtask

  task automatic test_reset_midframe();
    run_frame(20, 10, 2, 2);
    run_frame(20, 9, 0, -1);
  endtask

  initial begin
    test_reset();
    test_random_frames();
    test_short_lines();
    test_backpressure();
    test_incomplete();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
